// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, request presented, awaiting response)
//   owner_e     : which pipeline port owns the outstanding transaction
//   ADDR_W      : default byte-address width
//   DATA_W      : default data width
package riscv_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority pick between fetch and data requests, with a fetch starvation counter.
// Data wins ties unless fetch has lost STARVE_LIMIT consecutive contested picks.
//   clk, reset  : clock and synchronous active-high reset
//   pick_en     : arbiter is idle and will act on this cycle's pick
//   if_req      : fetch request
//   dm_req      : data request
//   pick_if     : fetch wins this cycle (combinational)
//   pick_dm     : data wins this cycle (combinational)
module mem_arb_prio #(
  parameter  int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic pick_en,
  input  logic if_req,
  input  logic dm_req,
  output logic pick_if,
  output logic pick_dm
);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  always_comb begin
    starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    pick_if = if_req && (!dm_req || starved);
    pick_dm = dm_req && !pick_if;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pick_en) begin
      if (pick_if) begin
        starve_cnt <= '0;
      end else if (if_req && pick_dm && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// load/store stage (DM). One transaction outstanding at a time.
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr                  : fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata       : fetch accept pulse, data pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb : load/store request, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata       : data accept pulse, response pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata    : memory accept, response valid, read data
//   arb_busy                        : a transaction is in flight
//   arb_err                         : sticky, a response arrived while not waiting
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AW           = ADDR_W,
  parameter int unsigned DW           = DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wstrb,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            arb_busy,
  output logic            arb_err
);

  arb_state_e state;
  owner_e     owner;
  logic       pick_if;
  logic       pick_dm;
  logic       idle;

  assign idle = (state == ST_IDLE);

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .reset   (reset),
    .pick_en (idle),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .pick_if (pick_if),
    .pick_dm (pick_dm)
  );

  // Grants are combinational so the requester sees acceptance in its request cycle;
  // masked during reset because no latch happens on that edge.
  always_comb begin
    if_gnt   = idle && !reset && pick_if;
    dm_gnt   = idle && !reset && pick_dm;
    arb_busy = !idle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      arb_err   <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;

      if (mem_rvalid && (state != ST_WAIT)) begin
        arb_err <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (pick_if) begin
            state     <= ST_REQ;
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end else if (pick_dm) begin
            state     <= ST_REQ;
            owner     <= OWN_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_we ? dm_wstrb : '0;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state   <= ST_WAIT;
            mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state <= ST_IDLE;
            if (owner == OWN_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_wstrb;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          arb_busy;
  logic          arb_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_wstrb   (dm_wstrb),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .arb_busy   (arb_busy),
    .arb_err    (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_wstrb   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, arb_busy, arb_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000000",
               {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, arb_busy, arb_err});
    end
    checks++;
    if ({if_rdata, dm_rdata, mem_addr, mem_wdata, mem_wstrb} !== 132'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {if_rdata, dm_rdata, mem_addr, mem_wdata, mem_wstrb});
    end
    checks++;
    if (dut.u_prio.starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_starve got %0d exp 0", dut.u_prio.starve_cnt);
    end
  endtask

  task automatic test_fetch();
    if_req  = 1'b1;
    if_addr = 32'h100;
    #1;
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_gnt got %b exp 10", {if_gnt, dm_gnt});
    end
    tick();
    if_req  = 1'b0;
    if_addr = '0;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb, if_gnt} !== {1'b1, 1'b0, 32'h100, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_memreq got req=%b we=%b addr=%h strb=%b gnt=%b exp 1 0 00000100 0000 0",
               mem_req, mem_we, mem_addr, mem_wstrb, if_gnt);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++;
    if ({mem_req, arb_busy} !== 2'b01) begin
      errors++;
      $display("FAIL fetch_wait got req=%b busy=%b exp 0 1", mem_req, arb_busy);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00500093;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    checks++;
    if ({if_rvalid, dm_rvalid, arb_busy, if_rdata} !== {3'b100, 32'h00500093}) begin
      errors++;
      $display("FAIL fetch_rvalid got if=%b dm=%b busy=%b data=%h exp 1 0 0 00500093",
               if_rvalid, dm_rvalid, arb_busy, if_rdata);
    end
    tick();
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h00500093}) begin
      errors++;
      $display("FAIL fetch_hold got v=%b data=%h exp 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h2000;
    dm_wdata = 32'hDEADBEEF;
    dm_wstrb = 4'b0011;
    #1;
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL store_gnt got %b exp 01", {if_gnt, dm_gnt});
    end
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !==
          {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin
        errors++;
        $display("FAIL store_hold%0d got req=%b we=%b addr=%h wdata=%h strb=%b exp 1 1 00002000 deadbeef 0011",
                 k, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      if (k == 3) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_drop got %b exp 0", mem_req);
    end
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({dm_rvalid, if_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL store_ack got dm=%b if=%b exp 1 0", dm_rvalid, if_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic exp_if;
    logic [2:0] exp_cnt;
    if_req  = 1'b1;
    if_addr = 32'h400;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h800;
    for (int i = 0; i < 10; i++) begin
      exp_if  = ((i % 5) == 4);
      exp_cnt = exp_if ? 3'd0 : 3'((i % 5) + 1);
      #1;
      checks++;
      if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
        errors++;
        $display("FAIL starve_gnt%0d got %b exp %b", i, {if_gnt, dm_gnt}, {exp_if, !exp_if});
      end
      tick();
      checks++;
      if ({if_gnt, dm_gnt, mem_addr, dut.u_prio.starve_cnt} !==
          {2'b00, (exp_if ? 32'h400 : 32'h800), exp_cnt}) begin
        errors++;
        $display("FAIL starve_req%0d got gnt=%b addr=%h cnt=%0d exp 00 %h %0d", i,
                 {if_gnt, dm_gnt}, mem_addr, dut.u_prio.starve_cnt,
                 (exp_if ? 32'h400 : 32'h800), exp_cnt);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA000 + i;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if ({if_rvalid, dm_rvalid, (exp_if ? if_rdata : dm_rdata)} !== {exp_if, !exp_if, 32'hA000 + i}) begin
        errors++;
        $display("FAIL starve_rsp%0d got if=%b dm=%b data=%h exp %b %b %h", i, if_rvalid, dm_rvalid,
                 (exp_if ? if_rdata : dm_rdata), exp_if, !exp_if, 32'hA000 + i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({if_rvalid, dm_rvalid, arb_busy, arb_err} !== 4'b0001) begin
      errors++;
      $display("FAIL stray got if=%b dm=%b busy=%b err=%b exp 0 0 0 1", if_rvalid, dm_rvalid, arb_busy, arb_err);
    end
    repeat (3) tick();
    checks++;
    if (arb_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_sticky got %b exp 1", arb_err);
    end
  endtask

  task automatic test_reset_in_wait();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (arb_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear_err got %b exp 0", arb_err);
    end
    if_req  = 1'b1;
    if_addr = 32'h300;
    tick();
    idle_inputs();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++;
    if ({mem_req, arb_busy} !== 2'b01) begin
      errors++;
      $display("FAIL rst_inwait got req=%b busy=%b exp 0 1", mem_req, arb_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, arb_busy, arb_err, mem_addr, if_rdata} !==
        {8'h00, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_wait_out got ctl=%b addr=%h ifd=%h exp 0",
               {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, arb_busy, arb_err}, mem_addr, if_rdata);
    end
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if ({if_rvalid, dm_rvalid, arb_busy, arb_err} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_late_rsp got if=%b dm=%b busy=%b err=%b exp 0 0 0 1", if_rvalid, dm_rvalid, arb_busy, arb_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random_latency();
    int m_cnt = 0;
    int sel, g, r;
    logic ir, dr, exp_if, we, exp_we;
    logic [31:0] ia, da, wd, rd, exp_addr;
    logic [3:0] st, exp_strb;
    for (int t = 0; t < 16; t++) begin
      sel = $urandom_range(2, 0);
      ir  = (sel != 1);
      dr  = (sel != 0);
      ia  = $urandom & 32'hFFFF_FFFC;
      da  = $urandom;
      we  = 1'($urandom_range(1, 0));
      wd  = $urandom;
      st  = 4'($urandom_range(15, 0));
      exp_if = ir && (!dr || (m_cnt >= SL));
      if (exp_if) m_cnt = 0;
      else if (ir && m_cnt < SL) m_cnt++;
      exp_addr = exp_if ? ia : da;
      exp_we   = exp_if ? 1'b0 : we;
      exp_strb = exp_we ? st : 4'h0;
      if_req = ir; if_addr = ia;
      dm_req = dr; dm_addr = da; dm_we = we; dm_wdata = wd; dm_wstrb = st;
      #1;
      checks++;
      if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
        errors++;
        $display("FAIL rnd_gnt%0d got %b exp %b", t, {if_gnt, dm_gnt}, {exp_if, !exp_if});
      end
      tick();
      idle_inputs();
      g = $urandom_range(5, 0);
      for (int k = 0; k <= g; k++) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, exp_we, exp_addr, exp_strb} ||
            (exp_we && mem_wdata !== wd)) begin
          errors++;
          $display("FAIL rnd_req%0d got req=%b we=%b addr=%h strb=%b wd=%h exp 1 %b %h %b %h", t,
                   mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, exp_we, exp_addr, exp_strb, wd);
        end
        if (k == g) mem_gnt = 1'b1;
        tick();
      end
      mem_gnt = 1'b0;
      r = $urandom_range(8, 1);
      for (int k = 1; k < r; k++) begin
        checks++;
        if ({mem_req, if_rvalid, dm_rvalid, arb_busy} !== 4'b0001) begin
          errors++;
          $display("FAIL rnd_wait%0d got req=%b if=%b dm=%b busy=%b exp 0 0 0 1", t,
                   mem_req, if_rvalid, dm_rvalid, arb_busy);
        end
        tick();
      end
      rd = $urandom;
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if ({if_rvalid, dm_rvalid, (exp_if ? if_rdata : dm_rdata), arb_err} !== {exp_if, !exp_if, rd, 1'b0}) begin
        errors++;
        $display("FAIL rnd_rsp%0d got if=%b dm=%b data=%h err=%b exp %b %b %h 0", t, if_rvalid, dm_rvalid,
                 (exp_if ? if_rdata : dm_rdata), arb_err, exp_if, !exp_if, rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_starvation();
    test_stray_rvalid();
    test_reset_in_wait();
    test_random_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
